// File: rtl/clock_set_pkg.sv
// rtl/clock_set_pkg.sv - shared types and constants for the clock/alarm set controller
package clock_set_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_HOUR,
        ST_SET_MIN,
        ST_LOAD,
        ST_STOP
    } state_t;

    typedef enum logic {
        TGT_TIME,
        TGT_ALARM
    } tgt_t;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } hhmm_t;

    localparam int HOUR_MAX       = 23;
    localparam int MIN_MAX        = 59;
    localparam int MIN_PER_HOUR   = MIN_MAX + 1;
    localparam int DAY_MIN        = (HOUR_MAX + 1) * MIN_PER_HOUR;

    localparam int HOLD_CYCLES_DEF = 12;
    localparam int TIMEOUT_S_DEF   = 10;
    localparam int SNOOZE_MIN_DEF  = 5;

endpackage

// File: rtl/bcd_hhmm_add.sv
// rtl/bcd_hhmm_add.sv - combinational BCD hh:mm plus N minutes with 24 h wrap
module bcd_hhmm_add
    import clock_set_pkg::*;
(
    input  hhmm_t      a,
    input  logic [6:0] n_min,
    output hhmm_t      sum
);

    logic [11:0] tot_in;
    logic [11:0] tot;
    logic [11:0] wrapped;
    logic [11:0] hours;
    logic [11:0] mins;

    // Work in minutes-of-day: one wrap subtraction suffices since n_min < one hour + 1.
    always_comb begin
        tot_in  = 12'(a.h1) * 12'(10 * MIN_PER_HOUR)
                + 12'(a.h0) * 12'(MIN_PER_HOUR)
                + 12'(a.m1) * 12'd10
                + 12'(a.m0);
        tot     = tot_in + 12'(n_min);
        wrapped = (tot >= 12'(DAY_MIN)) ? tot - 12'(DAY_MIN) : tot;
        hours   = wrapped / 12'(MIN_PER_HOUR);
        mins    = wrapped % 12'(MIN_PER_HOUR);
        sum.h1  = 2'(hours / 12'd10);
        sum.h0  = 4'(hours % 12'd10);
        sum.m1  = 4'(mins / 12'd10);
        sum.m0  = 4'(mins % 12'd10);
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - front-panel set/alarm controller; CLOCK_SET_SNOOZE_EN adds snooze on inc
module clock_set_ctrl
    import clock_set_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int TIMEOUT_S   = TIMEOUT_S_DEF,
    parameter int SNOOZE_MIN  = SNOOZE_MIN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic       btn_mode,
    input  logic       btn_alm,
    input  logic       btn_inc,
    input  logic       btn_ok,
    input  logic       btn_arm,
    input  logic       alarm_active,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       STOP_al,
    output logic       AL_ON,
    output logic       edit_hour,
    output logic       edit_min
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_S + 1);

    state_t        state_q, state_d;
    tgt_t          tgt_q, tgt_d;
    hhmm_t         edit_q, edit_d;
    hhmm_t         sh_q, sh_d;
    logic          al_on_q, al_on_d;
    logic          snooze_q, snooze_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [4:0]    btn_q;
    logic [4:0]    btns;
    logic [4:0]    press;
    logic          sel_ok, sel_inc, sel_mode, sel_alm, sel_arm;
    hhmm_t         add_a;
    hhmm_t         add_sum;
    logic [6:0]    add_n;

    assign btns     = {btn_arm, btn_alm, btn_mode, btn_inc, btn_ok};
    assign press    = btns & ~btn_q;
    assign sel_ok   = press[0];
    assign sel_inc  = press[1] & ~press[0];
    assign sel_mode = press[2] & ~|press[1:0];
    assign sel_alm  = press[3] & ~|press[2:0];
    assign sel_arm  = press[4] & ~|press[3:0];

    // One adder serves hour steps (+60), minute steps (+1) and snooze from the shadow alarm.
    always_comb begin
        add_a = (state_q == ST_IDLE) ? sh_q : edit_q;
        case (state_q)
            ST_SET_HOUR: add_n = 7'(MIN_PER_HOUR);
            ST_SET_MIN:  add_n = 7'd1;
            default:     add_n = 7'(SNOOZE_MIN);
        endcase
    end

    bcd_hhmm_add u_add (
        .a     (add_a),
        .n_min (add_n),
        .sum   (add_sum)
    );

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        edit_d   = edit_q;
        sh_d     = sh_q;
        al_on_d  = al_on_q;
        snooze_d = snooze_q;
        hold_d   = hold_q;
        tmo_d    = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_ok) begin
                    if (alarm_active) begin
                        state_d  = ST_STOP;
                        hold_d   = HW'(HOLD_CYCLES);
                        snooze_d = 1'b0;
                    end
                end else if (sel_inc) begin
`ifdef CLOCK_SET_SNOOZE_EN
                    if (alarm_active) begin
                        state_d  = ST_LOAD;
                        tgt_d    = TGT_ALARM;
                        edit_d   = add_sum;
                        sh_d     = add_sum;
                        hold_d   = HW'(HOLD_CYCLES);
                        snooze_d = 1'b1;
                    end
`endif
                end else if (sel_mode) begin
                    state_d = ST_SET_HOUR;
                    tgt_d   = TGT_TIME;
                    edit_d  = '0;
                    tmo_d   = TW'(TIMEOUT_S);
                end else if (sel_alm) begin
                    state_d = ST_SET_HOUR;
                    tgt_d   = TGT_ALARM;
                    edit_d  = sh_q;
                    tmo_d   = TW'(TIMEOUT_S);
                end else if (sel_arm) begin
                    al_on_d = ~al_on_q;
                end
            end
            ST_SET_HOUR, ST_SET_MIN: begin
                if (sel_ok) begin
                    tmo_d = TW'(TIMEOUT_S);
                    if (state_q == ST_SET_HOUR) begin
                        state_d = ST_SET_MIN;
                    end else begin
                        state_d  = ST_LOAD;
                        hold_d   = HW'(HOLD_CYCLES);
                        snooze_d = 1'b0;
                        if (tgt_q == TGT_ALARM) sh_d = edit_q;
                    end
                end else if (sel_inc) begin
                    tmo_d = TW'(TIMEOUT_S);
                    if (state_q == ST_SET_HOUR) begin
                        edit_d.h1 = add_sum.h1;
                        edit_d.h0 = add_sum.h0;
                    end else begin
                        edit_d.m1 = add_sum.m1;
                        edit_d.m0 = add_sum.m0;
                    end
                end else if (tick_1s) begin
                    if (tmo_q <= TW'(1)) state_d = ST_IDLE;
                    else tmo_d = tmo_q - TW'(1);
                end
            end
            ST_LOAD, ST_STOP: begin
                if (hold_q <= HW'(1)) state_d = ST_IDLE;
                else hold_d = hold_q - HW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tgt_q    <= TGT_TIME;
            edit_q   <= '0;
            sh_q     <= '0;
            al_on_q  <= 1'b0;
            snooze_q <= 1'b0;
            hold_q   <= '0;
            tmo_q    <= '0;
            btn_q    <= '0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            edit_q   <= edit_d;
            sh_q     <= sh_d;
            al_on_q  <= al_on_d;
            snooze_q <= snooze_d;
            hold_q   <= hold_d;
            tmo_q    <= tmo_d;
            btn_q    <= btns;
        end
    end

    assign H_in1     = edit_q.h1;
    assign H_in0     = edit_q.h0;
    assign M_in1     = edit_q.m1;
    assign M_in0     = edit_q.m0;
    assign LD_time   = (state_q == ST_LOAD) && (tgt_q == TGT_TIME);
    assign LD_alarm  = (state_q == ST_LOAD) && (tgt_q == TGT_ALARM);
    assign STOP_al   = (state_q == ST_STOP) || ((state_q == ST_LOAD) && snooze_q);
    assign AL_ON     = al_on_q;
    assign edit_hour = (state_q == ST_SET_HOUR);
    assign edit_min  = (state_q == ST_SET_MIN);

endmodule
